// File: rtl/stream_cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stream_cmp_pkg
//  Purpose  : Shared result encodings and helpers for the streaming comparator.
//  Revision : 1.0  initial release
// ============================================================================
package stream_cmp_pkg;

    // One-hot result encodings, bit order {lt, eq, gt}
    localparam logic [2:0] RES_LT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_GT   = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;

    // Saturating increment of a counter that is 'width' bits wide (width <= 32).
    // The counter is carried zero-extended in 32 bits so one helper serves any CNT_W.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int width);
        logic [31:0] lim;
        lim = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (cnt >= lim) ? lim : (cnt + 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_comparator_cmp_core.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_core
//  Purpose  : Combinational magnitude compare of two operands, signed or
//             unsigned, producing one-hot lt/eq/gt.
//  Revision : 1.0  initial release
// ============================================================================
module cmp_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    logic [WIDTH-1:0] w_a_key;
    logic [WIDTH-1:0] w_b_key;

    // Flipping the sign bit maps two's-complement order onto unsigned order
    always_comb begin
        w_a_key = a ^ {signed_mode, {(WIDTH-1){1'b0}}};
        w_b_key = b ^ {signed_mode, {(WIDTH-1){1'b0}}};
        eq      = (a == b);
        lt      = (w_a_key < w_b_key);
        gt      = !lt && !eq;
    end

endmodule
`default_nettype wire

// File: rtl/stream_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : stream_comparator
//  Purpose  : Valid/ready streaming comparator with registered one-hot result
//             and per-frame statistics (min/max of a, LT/EQ/GT counts).
//  Revision : 1.0  initial release
// ============================================================================
module stream_comparator
    import stream_cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_lt,
    output logic             out_eq,
    output logic             out_gt,
    output logic             out_last,
    output logic             stat_valid,
    output logic [WIDTH-1:0] stat_min,
    output logic [WIDTH-1:0] stat_max,
    output logic [CNT_W-1:0] stat_lt,
    output logic [CNT_W-1:0] stat_eq,
    output logic [CNT_W-1:0] stat_gt
);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic             out_valid_q,    out_valid_d;
    logic [2:0]       res_q,          res_d;
    logic             out_last_q,     out_last_d;
    logic             frame_active_q, frame_active_d;
    logic             mode_q,         mode_d;
    logic [WIDTH-1:0] min_q,          min_d;
    logic [WIDTH-1:0] max_q,          max_d;
    logic [CNT_W-1:0] cnt_lt_q,       cnt_lt_d;
    logic [CNT_W-1:0] cnt_eq_q,       cnt_eq_d;
    logic [CNT_W-1:0] cnt_gt_q,       cnt_gt_d;
    logic             stat_valid_q,   stat_valid_d;
    logic [WIDTH-1:0] stat_min_q,     stat_min_d;
    logic [WIDTH-1:0] stat_max_q,     stat_max_d;
    logic [CNT_W-1:0] stat_lt_q,      stat_lt_d;
    logic [CNT_W-1:0] stat_eq_q,      stat_eq_d;
    logic [CNT_W-1:0] stat_gt_q,      stat_gt_d;

    // ---------------------------------------------------------------------
    // Combinational helpers
    // ---------------------------------------------------------------------
    logic             w_accept;
    logic             w_mode;
    logic             w_lt, w_eq, w_gt;
    logic             w_min_lt, w_min_eq, w_min_gt;
    logic             w_max_lt, w_max_eq, w_max_gt;
    logic             w_unused_cmp;
    logic [WIDTH-1:0] w_new_min, w_new_max;
    logic [CNT_W-1:0] w_new_lt, w_new_eq, w_new_gt;

    assign in_ready = !out_valid_q || out_ready;
    assign w_accept = in_valid && in_ready;
    // Mode is taken from the port only on the first beat; later beats reuse the latched one
    assign w_mode   = frame_active_q ? mode_q : signed_mode;

    cmp_core #(.WIDTH(WIDTH)) u_cmp_ab (
        .a(in_a), .b(in_b), .signed_mode(w_mode),
        .lt(w_lt), .eq(w_eq), .gt(w_gt)
    );

    cmp_core #(.WIDTH(WIDTH)) u_cmp_min (
        .a(in_a), .b(min_q), .signed_mode(w_mode),
        .lt(w_min_lt), .eq(w_min_eq), .gt(w_min_gt)
    );

    cmp_core #(.WIDTH(WIDTH)) u_cmp_max (
        .a(in_a), .b(max_q), .signed_mode(w_mode),
        .lt(w_max_lt), .eq(w_max_eq), .gt(w_max_gt)
    );

    // Only "a below min" and "a above max" matter for the running extremes
    assign w_unused_cmp = ^{w_min_eq, w_min_gt, w_max_lt, w_max_eq};

    // Frame accumulators including the beat currently on the input
    always_comb begin
        w_new_min = min_q;
        w_new_max = max_q;
        w_new_lt  = cnt_lt_q;
        w_new_eq  = cnt_eq_q;
        w_new_gt  = cnt_gt_q;
        if (!frame_active_q) begin
            w_new_min = in_a;
            w_new_max = in_a;
            w_new_lt  = CNT_W'(w_lt);
            w_new_eq  = CNT_W'(w_eq);
            w_new_gt  = CNT_W'(w_gt);
        end else begin
            if (w_min_lt) w_new_min = in_a;
            if (w_max_gt) w_new_max = in_a;
            if (w_lt) w_new_lt = CNT_W'(sat_inc(32'(cnt_lt_q), CNT_W));
            if (w_eq) w_new_eq = CNT_W'(sat_inc(32'(cnt_eq_q), CNT_W));
            if (w_gt) w_new_gt = CNT_W'(sat_inc(32'(cnt_gt_q), CNT_W));
        end
    end

    // Next-state: output register/handshake, frame tracking and stat capture
    always_comb begin
        out_valid_d    = out_valid_q;
        res_d          = res_q;
        out_last_d     = out_last_q;
        frame_active_d = frame_active_q;
        mode_d         = mode_q;
        min_d          = min_q;
        max_d          = max_q;
        cnt_lt_d       = cnt_lt_q;
        cnt_eq_d       = cnt_eq_q;
        cnt_gt_d       = cnt_gt_q;
        stat_valid_d   = 1'b0;
        stat_min_d     = stat_min_q;
        stat_max_d     = stat_max_q;
        stat_lt_d      = stat_lt_q;
        stat_eq_d      = stat_eq_q;
        stat_gt_d      = stat_gt_q;

        if (w_accept) begin
            out_valid_d = 1'b1;
            res_d       = w_lt ? RES_LT : (w_eq ? RES_EQ : RES_GT);
            out_last_d  = in_last;
        end else if (out_ready) begin
            // Clear on drain so the result lines read zero while idle
            out_valid_d = 1'b0;
            res_d       = RES_NONE;
            out_last_d  = 1'b0;
        end

        if (w_accept) begin
            if (in_last) begin
                stat_valid_d   = 1'b1;
                stat_min_d     = w_new_min;
                stat_max_d     = w_new_max;
                stat_lt_d      = w_new_lt;
                stat_eq_d      = w_new_eq;
                stat_gt_d      = w_new_gt;
                frame_active_d = 1'b0;
                mode_d         = 1'b0;
                min_d          = '0;
                max_d          = '0;
                cnt_lt_d       = '0;
                cnt_eq_d       = '0;
                cnt_gt_d       = '0;
            end else begin
                frame_active_d = 1'b1;
                mode_d         = w_mode;
                min_d          = w_new_min;
                max_d          = w_new_max;
                cnt_lt_d       = w_new_lt;
                cnt_eq_d       = w_new_eq;
                cnt_gt_d       = w_new_gt;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            res_q          <= RES_NONE;
            out_last_q     <= 1'b0;
            frame_active_q <= 1'b0;
            mode_q         <= 1'b0;
            min_q          <= '0;
            max_q          <= '0;
            cnt_lt_q       <= '0;
            cnt_eq_q       <= '0;
            cnt_gt_q       <= '0;
            stat_valid_q   <= 1'b0;
            stat_min_q     <= '0;
            stat_max_q     <= '0;
            stat_lt_q      <= '0;
            stat_eq_q      <= '0;
            stat_gt_q      <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            res_q          <= res_d;
            out_last_q     <= out_last_d;
            frame_active_q <= frame_active_d;
            mode_q         <= mode_d;
            min_q          <= min_d;
            max_q          <= max_d;
            cnt_lt_q       <= cnt_lt_d;
            cnt_eq_q       <= cnt_eq_d;
            cnt_gt_q       <= cnt_gt_d;
            stat_valid_q   <= stat_valid_d;
            stat_min_q     <= stat_min_d;
            stat_max_q     <= stat_max_d;
            stat_lt_q      <= stat_lt_d;
            stat_eq_q      <= stat_eq_d;
            stat_gt_q      <= stat_gt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_lt     = res_q[2];
    assign out_eq     = res_q[1];
    assign out_gt     = res_q[0];
    assign out_last   = out_last_q;
    assign stat_valid = stat_valid_q;
    assign stat_min   = stat_min_q;
    assign stat_max   = stat_max_q;
    assign stat_lt    = stat_lt_q;
    assign stat_eq    = stat_eq_q;
    assign stat_gt    = stat_gt_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_comparator
//  Purpose  : Self-checking bench for stream_comparator (CNT_W=16 and CNT_W=2
//             instances driven with identical stimulus).
//  Revision : 1.0  initial release
// ============================================================================
module tb_stream_comparator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_a, in_b;
    logic       in_last, signed_mode, out_ready;

    logic        in_ready, out_valid, out_lt, out_eq, out_gt, out_last, stat_valid;
    logic [7:0]  stat_min, stat_max;
    logic [15:0] stat_lt, stat_eq, stat_gt;

    logic        in_ready2, out_valid2, out_lt2, out_eq2, out_gt2, out_last2, stat_valid2;
    logic [7:0]  stat_min2, stat_max2;
    logic [1:0]  stat_lt2, stat_eq2, stat_gt2;

    always #5 clk = ~clk;

    stream_comparator #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .signed_mode(signed_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lt(out_lt), .out_eq(out_eq), .out_gt(out_gt), .out_last(out_last),
        .stat_valid(stat_valid), .stat_min(stat_min), .stat_max(stat_max),
        .stat_lt(stat_lt), .stat_eq(stat_eq), .stat_gt(stat_gt)
    );

    stream_comparator #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .signed_mode(signed_mode),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_lt(out_lt2), .out_eq(out_eq2), .out_gt(out_gt2), .out_last(out_last2),
        .stat_valid(stat_valid2), .stat_min(stat_min2), .stat_max(stat_max2),
        .stat_lt(stat_lt2), .stat_eq(stat_eq2), .stat_gt(stat_gt2)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sm;
        logic       last;
        logic [2:0] exp;
    } vec_t;

    typedef struct {
        logic [2:0] res;
        logic       last;
    } out_t;

    typedef struct {
        logic [7:0] mn;
        logic [7:0] mx;
        int         lt;
        int         eq;
        int         gt;
    } stat_t;

    out_t  oq[$];
    stat_t sq[$];
    int    tests = 0;
    int    fails = 0;

    // Reference model of the frame accumulators
    bit         m_active = 1'b0;
    bit         m_mode   = 1'b0;
    logic [7:0] m_min, m_max;
    int         m_lt, m_eq, m_gt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_cmp(input logic [7:0] a, input logic [7:0] b, input bit sm);
        if (a == b) return 3'b010;
        if (sm) return ($signed(a) < $signed(b)) ? 3'b100 : 3'b001;
        return (a < b) ? 3'b100 : 3'b001;
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_accept(input logic [7:0] a, input logic [7:0] b, input bit sm,
                                input bit last, output logic [2:0] r);
        bit md;
        md = m_active ? m_mode : sm;
        r  = ref_cmp(a, b, md);
        if (!m_active) begin
            m_min = a; m_max = a;
            m_lt = int'(r[2]); m_eq = int'(r[1]); m_gt = int'(r[0]);
        end else begin
            if (ref_cmp(a, m_min, md) == 3'b100) m_min = a;
            if (ref_cmp(a, m_max, md) == 3'b001) m_max = a;
            m_lt += int'(r[2]); m_eq += int'(r[1]); m_gt += int'(r[0]);
        end
        if (last) begin
            sq.push_back('{mn: m_min, mx: m_max, lt: m_lt, eq: m_eq, gt: m_gt});
            m_active = 1'b0;
        end else begin
            m_active = 1'b1;
            m_mode   = md;
        end
    endtask

    // Present one beat and hold it until accepted; expectations are queued at acceptance
    task automatic send(input logic [7:0] a, input logic [7:0] b, input bit sm, input bit last,
                        input logic [2:0] exp, input bit has_exp);
        logic [2:0] r;
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        in_valid = 1'b1; in_a = a; in_b = b; signed_mode = sm; in_last = last;
        while (!acc && n < 50) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                model_accept(a, b, sm, last, r);
                oq.push_back('{res: (has_exp ? exp : r), last: last});
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Output/stat monitor: pops expectations when a result transfers or stats pulse
    out_t  mon_e;
    stat_t mon_s;
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid)
                check("onehot", 32'($countones({out_lt, out_eq, out_gt})), 32'd1);
            else
                check("idle_zero", {28'd0, out_lt, out_eq, out_gt, out_last}, 32'd0);
            if (out_valid && out_ready) begin
                if (oq.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    mon_e = oq.pop_front();
                    check("result",      {29'd0, out_lt, out_eq, out_gt}, {29'd0, mon_e.res});
                    check("out_last",    {31'd0, out_last}, {31'd0, mon_e.last});
                    check("result_dut2", {28'd0, out_valid2, out_lt2, out_eq2, out_gt2},
                                         {28'd0, 1'b1, mon_e.res});
                end
            end
            if (stat_valid) begin
                check("stat_with_last", {31'd0, out_valid && out_last}, 32'd1);
                if (sq.size() == 0) begin
                    check("unexpected_stat", 32'd1, 32'd0);
                end else begin
                    mon_s = sq.pop_front();
                    check("stat_min", 32'(stat_min), 32'(mon_s.mn));
                    check("stat_max", 32'(stat_max), 32'(mon_s.mx));
                    check("stat_lt",  32'(stat_lt),  32'(sat(mon_s.lt, 65535)));
                    check("stat_eq",  32'(stat_eq),  32'(sat(mon_s.eq, 65535)));
                    check("stat_gt",  32'(stat_gt),  32'(sat(mon_s.gt, 65535)));
                    check("stat2_valid", {31'd0, stat_valid2}, 32'd1);
                    check("stat2_min", 32'(stat_min2), 32'(mon_s.mn));
                    check("stat2_max", 32'(stat_max2), 32'(mon_s.mx));
                    check("stat2_lt",  32'(stat_lt2),  32'(sat(mon_s.lt, 3)));
                    check("stat2_eq",  32'(stat_eq2),  32'(sat(mon_s.eq, 3)));
                    check("stat2_gt",  32'(stat_gt2),  32'(sat(mon_s.gt, 3)));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    vec_t vecs[10];

    initial begin
        vecs[0] = '{a: 8'h80, b: 8'h7F, sm: 1'b0, last: 1'b1, exp: 3'b001};
        vecs[1] = '{a: 8'h80, b: 8'h7F, sm: 1'b1, last: 1'b1, exp: 3'b100};
        vecs[2] = '{a: 8'h55, b: 8'h55, sm: 1'b0, last: 1'b1, exp: 3'b010};
        vecs[3] = '{a: 8'hFF, b: 8'h01, sm: 1'b1, last: 1'b1, exp: 3'b100};
        vecs[4] = '{a: 8'h00, b: 8'hFF, sm: 1'b0, last: 1'b1, exp: 3'b100};
        vecs[5] = '{a: 8'h7F, b: 8'h80, sm: 1'b1, last: 1'b1, exp: 3'b001};
        vecs[6] = '{a: 8'd5,   b: 8'd17, sm: 1'b0, last: 1'b0, exp: 3'b100};
        vecs[7] = '{a: 8'd200, b: 8'd17, sm: 1'b0, last: 1'b0, exp: 3'b001};
        vecs[8] = '{a: 8'd17,  b: 8'd17, sm: 1'b0, last: 1'b0, exp: 3'b010};
        vecs[9] = '{a: 8'd200, b: 8'd17, sm: 1'b0, last: 1'b1, exp: 3'b001};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
        signed_mode = 1'b0; out_ready = 1'b1;
        idle(2);
        check("rst_out_valid",  {31'd0, out_valid}, 32'd0);
        check("rst_results",    {28'd0, out_lt, out_eq, out_gt, out_last}, 32'd0);
        check("rst_stat_valid", {31'd0, stat_valid}, 32'd0);
        check("rst_stats",      {stat_min, stat_max, stat_lt}, 32'd0);
        rst = 1'b0;
        idle(1);
        check("rst_in_ready",   {31'd0, in_ready}, 32'd1);

        // Table: single-beat compares, then a 4-beat unsigned frame
        for (int i = 0; i < 10; i++)
            send(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].last, vecs[i].exp, 1'b1);
        idle(3);
        check("frame_min", 32'(stat_min), 32'd5);
        check("frame_max", 32'(stat_max), 32'd200);
        check("frame_lt",  32'(stat_lt),  32'd1);
        check("frame_eq",  32'(stat_eq),  32'd1);
        check("frame_gt",  32'(stat_gt),  32'd2);

        // Mode switch mid-frame: signed latched on beat 1
        send(8'h01, 8'h00, 1'b1, 1'b0, 3'b001, 1'b1);
        send(8'hFF, 8'h00, 1'b0, 1'b1, 3'b100, 1'b1);
        idle(3);
        check("latched_max", 32'(stat_max), 32'h01);
        check("latched_min", 32'(stat_min), 32'hFF);
        send(8'hFF, 8'h00, 1'b0, 1'b1, 3'b001, 1'b1);
        idle(3);
        check("newmode_minmax", {16'd0, stat_min, stat_max}, 32'h0000_FFFF);

        // Counter saturation on the narrow instance
        for (int i = 0; i < 5; i++)
            send(8'd3, 8'd3, 1'b0, (i == 4), 3'b010, 1'b1);
        idle(3);
        check("sat_eq2", 32'(stat_eq2), 32'd3);
        check("eq_wide", 32'(stat_eq),  32'd5);
        send(8'h42, 8'h10, 1'b0, 1'b1, 3'b001, 1'b1);
        idle(3);
        check("single_minmax", {16'd0, stat_min, stat_max}, 32'h0000_4242);

        // Backpressure: result held, second beat refused for 3 cycles
        out_ready = 1'b0;
        send(8'h10, 8'h20, 1'b0, 1'b1, 3'b100, 1'b1);
        in_valid = 1'b1; in_a = 8'h30; in_b = 8'h20; in_last = 1'b1; signed_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready",  {31'd0, in_ready}, 32'd0);
            check("bp_held",      {28'd0, out_valid, out_lt, out_eq, out_gt}, 32'b1100);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(8'h30, 8'h20, 1'b0, 1'b1, 3'b001, 1'b1);
        idle(3);

        // Reset mid-frame after two beats
        send(8'd50, 8'd1, 1'b0, 1'b0, 3'b001, 1'b1);
        send(8'd60, 8'd1, 1'b0, 1'b0, 3'b001, 1'b1);
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        m_active = 1'b0;
        oq.delete();
        sq.delete();
        check("midrst_outputs", {27'd0, out_valid, out_lt, out_eq, out_gt, stat_valid}, 32'd0);
        check("midrst_stats",   {stat_min, stat_max, stat_eq}, 32'd0);
        idle(1);
        check("midrst_no_pulse", {31'd0, stat_valid}, 32'd0);
        send(8'd9, 8'd9, 1'b0, 1'b0, 3'b010, 1'b1);
        send(8'd3, 8'd4, 1'b0, 1'b1, 3'b100, 1'b1);
        idle(3);
        check("postrst_minmax", {16'd0, stat_min, stat_max}, 32'h0000_0309);
        check("postrst_cnts",   {stat_lt[7:0], stat_eq[7:0], stat_gt[7:0]}, 32'h0001_0100);

        // Back-to-back frames: close then open on the next cycle
        send(8'd1, 8'd2, 1'b0, 1'b0, 3'b100, 1'b1);
        send(8'd6, 8'd2, 1'b0, 1'b1, 3'b001, 1'b1);
        send(8'd4, 8'd4, 1'b0, 1'b1, 3'b010, 1'b1);
        idle(3);
        check("b2b_last_minmax", {16'd0, stat_min, stat_max}, 32'h0000_0404);

        for (int i = 0; i < 20 && (oq.size() != 0 || sq.size() != 0); i++) idle(1);
        check("out_queue_empty",  32'(oq.size()), 32'd0);
        check("stat_queue_empty", 32'(sq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
